// File: rtl/muldiv_unit.sv
// Multi-cycle multiply/divide unit with architectural HI/LO and MTHI/MTLO writes.
// Optional MADD/MSUB (ops 6/7) are enabled by defining MULDIV_MADD_EN.
module muldiv_unit #(
    parameter int WIDTH      = 32,
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int W2   = 2 * WIDTH;
    localparam int MAXC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_DIV   = 3'd2,
        OP_DIVU  = 3'd3,
        OP_MTHI  = 3'd4,
        OP_MTLO  = 3'd5,
        OP_MADD  = 3'd6,
        OP_MSUB  = 3'd7
    } op_e;

    typedef enum logic {S_IDLE, S_BUSY} state_e;

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [2:0]       op_q, op_d;
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
    logic             done_q, done_d;

    function automatic logic is_multi(input logic [2:0] o);
        case (o)
            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: is_multi = 1'b1;
`ifdef MULDIV_MADD_EN
            OP_MADD, OP_MSUB:                   is_multi = 1'b1;
`endif
            default:                            is_multi = 1'b0;
        endcase
    endfunction

    // ---------------- result datapath (from latched operands) ----------------
    logic [W2-1:0]    sa_ext, sb_ext, sprod, uprod, acc;
    logic             a_neg, b_neg, div_signed;
    logic [WIDTH-1:0] a_mag, b_mag, b_div, uq, ur, q, r;
    logic [WIDTH-1:0] res_hi, res_lo;

    assign sa_ext = {{WIDTH{a_q[WIDTH-1]}}, a_q};
    assign sb_ext = {{WIDTH{b_q[WIDTH-1]}}, b_q};
    // Low 2W bits of the sign-extended product are the signed product.
    assign sprod  = sa_ext * sb_ext;
    assign uprod  = {{WIDTH{1'b0}}, a_q} * {{WIDTH{1'b0}}, b_q};

    // Signed divide runs on magnitudes and fixes signs afterwards.
    // MIN / -1 falls out naturally: |MIN| wraps back to MIN with remainder 0.
    assign div_signed = (op_q == OP_DIV);
    assign a_neg      = div_signed & a_q[WIDTH-1];
    assign b_neg      = div_signed & b_q[WIDTH-1];
    assign a_mag      = a_neg ? -a_q : a_q;
    assign b_mag      = b_neg ? -b_q : b_q;
    assign b_div      = (b_q == '0) ? {{(WIDTH-1){1'b0}}, 1'b1} : b_mag;
    assign uq         = a_mag / b_div;
    assign ur         = a_mag % b_div;
    assign q          = (a_neg ^ b_neg) ? -uq : uq;
    assign r          = a_neg ? -ur : ur;

`ifdef MULDIV_MADD_EN
    assign acc = (op_q == OP_MSUB) ? ({hi_q, lo_q} - sprod) : ({hi_q, lo_q} + sprod);
`else
    assign acc = {hi_q, lo_q};
`endif

    always_comb begin
        res_hi = hi_q;
        res_lo = lo_q;
        case (op_q)
            OP_MULT:  {res_hi, res_lo} = sprod;
            OP_MULTU: {res_hi, res_lo} = uprod;
            OP_DIV, OP_DIVU: begin
                if (b_q == '0) begin
                    res_hi = a_q;
                    res_lo = '1;
                end else begin
                    res_hi = r;
                    res_lo = q;
                end
            end
            OP_MADD, OP_MSUB: {res_hi, res_lo} = acc;
            default: ;
        endcase
    end

    // ---------------- control FSM ----------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_d  = a;
                    b_d  = b;
                    op_d = op;
                    if (op == OP_MTHI) hi_d = a;
                    if (op == OP_MTLO) lo_d = a;
                    if (is_multi(op)) begin
                        state_d = S_BUSY;
                        cnt_d   = (op == OP_DIV || op == OP_DIVU) ? CW'(DIV_CYCLES)
                                                                  : CW'(MUL_CYCLES);
                    end
                end
            end
            S_BUSY: begin
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = S_IDLE;
                    hi_d    = res_hi;
                    lo_d    = res_lo;
                    done_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
        end
    end

    assign busy = (state_q == S_BUSY);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: arithmetic reference model compared every
// cycle, plus directed vectors with hand-computed HI/LO and busy-length values.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [2:0]  op_i;
    logic [31:0] a_i, b_i;
    logic        busy, done;
    logic [31:0] hi, lo;

    int n_chk  = 0;
    int n_fail = 0;

    muldiv_unit #(.WIDTH(32), .MUL_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op_i), .a(a_i), .b(b_i),
        .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: results from plain 64-bit arithmetic.
    function automatic logic [63:0] model_res(input logic [2:0] o, input logic [31:0] x,
                                              input logic [31:0] y, input logic [63:0] hl);
        longint sx, sy;
        logic [63:0] res;
        sx  = longint'($signed(x));
        sy  = longint'($signed(y));
        res = hl;
        case (o)
            3'd0: res = sx * sy;
            3'd1: res = {32'h0, x} * {32'h0, y};
            3'd2: if (y == 0) res = {x, 32'hFFFF_FFFF};
                  else        res = {32'(sx % sy), 32'(sx / sy)};
            3'd3: if (y == 0) res = {x, 32'hFFFF_FFFF};
                  else        res = {x % y, x / y};
            3'd6: res = hl + sx * sy;
            3'd7: res = hl - sx * sy;
            default: ;
        endcase
        return res;
    endfunction

    logic [31:0] m_hi = '0, m_lo = '0;
    logic        m_busy = 1'b0, m_done = 1'b0;
    logic [63:0] m_pend = '0;
    int          m_left = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_hi <= '0; m_lo <= '0; m_busy <= 1'b0; m_done <= 1'b0; m_left <= 0;
        end else begin
            m_done <= 1'b0;
            if (m_left > 0) begin
                m_left <= m_left - 1;
                if (m_left == 1) begin
                    {m_hi, m_lo} <= m_pend;
                    m_busy <= 1'b0;
                    m_done <= 1'b1;
                end
            end else if (start) begin
                case (op_i)
                    3'd4: m_hi <= a_i;
                    3'd5: m_lo <= a_i;
`ifdef MULDIV_MADD_EN
                    3'd0, 3'd1, 3'd2, 3'd3, 3'd6, 3'd7: begin
`else
                    3'd0, 3'd1, 3'd2, 3'd3: begin
`endif
                        m_pend <= model_res(op_i, a_i, b_i, {m_hi, m_lo});
                        m_left <= (op_i == 3'd2 || op_i == 3'd3) ? 10 : 5;
                        m_busy <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    always @(negedge clk) begin
        chk("cyc_busy", 32'(busy), 32'(m_busy));
        chk("cyc_done", 32'(done), 32'(m_done));
        chk("cyc_hi", hi, m_hi);
        chk("cyc_lo", lo, m_lo);
    end

    // Called just after a negedge; returns at the negedge where busy has fallen.
    task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                          input int ncyc, input logic [31:0] ehi, input logic [31:0] elo,
                          input string nm, input bit inj);
        int cnt = 0;
        #1;
        start = 1'b1; op_i = o; a_i = x; b_i = y;
        @(negedge clk);
        for (int i = 0; i < 60; i++) begin
            if (!busy) break;
            cnt++;
            #1;
            if (inj && cnt == 3) begin
                start = 1'b1; op_i = 3'd5; a_i = 32'd5; b_i = 32'd0;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        chk({nm, "_busycyc"}, 32'(cnt), 32'(ncyc));
        chk({nm, "_done"}, 32'(done), 32'd1);
        chk({nm, "_hi"}, hi, ehi);
        chk({nm, "_lo"}, lo, elo);
    endtask

    initial begin
        int seen;
        rst_n = 1'b1; start = 1'b0; op_i = '0; a_i = '0; b_i = '0;
        #1 rst_n = 1'b0;
        @(negedge clk);
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run_op(3'd0, 32'hFFFF_FFFE, 32'd3, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFA, "mult", 1'b0);
        @(negedge clk);
        chk("mult_done_fall", 32'(done), 32'd0);
        run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5, 32'hFFFF_FFFE, 32'h0000_0001, "multu", 1'b0);
        run_op(3'd2, 32'hFFFF_FFF9, 32'd2, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD, "div", 1'b0);
        // MTLO 5 issued mid-operation must be dropped
        run_op(3'd3, 32'd100, 32'd0, 10, 32'd100, 32'hFFFF_FFFF, "divu0", 1'b1);

        // MTHI accepted in the done cycle
        #1 start = 1'b1; op_i = 3'd4; a_i = 32'h1234; b_i = '0;
        @(negedge clk);
        chk("mthi_hi", hi, 32'h1234);
        chk("mthi_lo", lo, 32'hFFFF_FFFF);
        chk("mthi_busy", 32'(busy), 32'd0);
        chk("mthi_done", 32'(done), 32'd0);
        #1 start = 1'b0;
        @(negedge clk);

        run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'h0, 32'h8000_0000, "div_ovf", 1'b0);
        run_op(3'd2, 32'd7, 32'hFFFF_FFFE, 10, 32'd1, 32'hFFFF_FFFD, "div_negb", 1'b0);

`ifdef MULDIV_MADD_EN
        run_op(3'd6, 32'd2, 32'd3, 5, 32'd2, 32'd3, "madd", 1'b0);
        run_op(3'd7, 32'd2, 32'd3, 5, 32'd1, 32'hFFFF_FFFD, "msub", 1'b0);
`else
        #1 start = 1'b1; op_i = 3'd6; a_i = 32'd2; b_i = 32'd3;
        @(negedge clk);
        #1 op_i = 3'd7;
        @(negedge clk);
        chk("undef_busy", 32'(busy), 32'd0);
        chk("undef_hi", hi, 32'd1);
        chk("undef_lo", lo, 32'hFFFF_FFFD);
        #1 start = 1'b0;
        @(negedge clk);
        chk("undef_done", 32'(done), 32'd0);
`endif

        // Reset in the middle of a divide
        #1 start = 1'b1; op_i = 3'd2; a_i = 32'hFFFF_FFF9; b_i = 32'd2;
        @(negedge clk);
        #1 start = 1'b0;
        repeat (3) @(negedge clk);
        chk("mid_busy", 32'(busy), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_done", 32'(done), 32'd0);
        chk("arst_hi", hi, 32'd0);
        chk("arst_lo", lo, 32'd0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (done) seen++;
        end
        chk("arst_no_done", 32'(seen), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
